alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 113 +++++++++++
 tb/tb_alu_writeback.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// ALU result writeback stage: writes single-word results in one cycle and wide results
// (mul / div-mod) in two, and tracks overflow and illegal-function exceptions.
module alu_writeback #(
    parameter logic [3:0] HI_REG = 4'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [2:0]  ALU_FUNC,
    input  logic [31:0] alu_out,
    input  logic        OF_detect,
    input  logic [3:0]  dest_reg,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        stall,
    output logic        of_flag,
    input  logic        of_clear,
    output logic        exc_pulse,
    output logic [2:0]  exc_func
);

    typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

    state_e      state_q, state_d;
    logic [2:0]  func_q;
    logic [31:0] data_q;
    logic        ovf_q;
    logic [3:0]  dest_q;
    logic        of_flag_q;
    logic [2:0]  exc_func_q;

    logic accept;
    logic in_ovf, in_exc;
    logic lo_exc, lo_wide;

    assign accept  = wb_valid && wb_ready;
    // Overflow only matters for add/sub; 110/111 are illegal function codes.
    assign in_ovf  = (ALU_FUNC[2:1] == 2'b00) && OF_detect;
    assign in_exc  = (ALU_FUNC[2:1] == 2'b11) || in_ovf;
    assign lo_exc  = (func_q[2:1] == 2'b11) || ((func_q[2:1] == 2'b00) && ovf_q);
    assign lo_wide = (func_q[2:1] == 2'b10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            func_q     <= '0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            dest_q     <= '0;
            of_flag_q  <= 1'b0;
            exc_func_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                func_q <= ALU_FUNC;
                data_q <= alu_out;
                ovf_q  <= OF_detect;
                dest_q <= dest_reg;
                if (in_exc) begin
                    exc_func_q <= ALU_FUNC;
                end
            end
            // A new overflow takes priority over a coincident clear.
            if (accept && in_ovf) begin
                of_flag_q <= 1'b1;
            end else if (of_clear) begin
                of_flag_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = StIdle;
        wb_ready  = 1'b1;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        exc_pulse = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = accept ? StLo : StIdle;
            end
            StLo: begin
                rf_we     = !lo_exc && (dest_q != 4'd0);
                rf_waddr  = dest_q;
                rf_wdata  = data_q[15:0];
                exc_pulse = lo_exc;
                wb_ready  = !lo_wide;
                if (lo_wide) begin
                    state_d = StHi;
                end else begin
                    state_d = accept ? StLo : StIdle;
                end
            end
            StHi: begin
                rf_we    = 1'b1;
                rf_waddr = HI_REG;
                rf_wdata = data_q[31:16];
                state_d  = accept ? StLo : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign stall    = !wb_ready;
    assign of_flag  = of_flag_q;
    assign exc_func = exc_func_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed cases plus random traffic against a
// queue-based model of the register-file write cycles each accepted result produces.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  ALU_FUNC;
    logic [31:0] alu_out;
    logic        OF_detect;
    logic [3:0]  dest_reg;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        stall;
    logic        of_flag;
    logic        of_clear;
    logic        exc_pulse;
    logic [2:0]  exc_func;

    alu_writeback #(.HI_REG(4'd15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .ALU_FUNC  (ALU_FUNC),
        .alu_out   (alu_out),
        .OF_detect (OF_detect),
        .dest_reg  (dest_reg),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .stall     (stall),
        .of_flag   (of_flag),
        .of_clear  (of_clear),
        .exc_pulse (exc_pulse),
        .exc_func  (exc_func)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        pulse;
        logic        idle;
    } cyc_t;

    localparam cyc_t IdleCyc = '{we: 1'b0, addr: 4'd0, data: 16'd0, pulse: 1'b0, idle: 1'b1};

    cyc_t       sched[$];
    cyc_t       cur;
    logic       m_of;
    logic [2:0] m_exc_func;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every DUT output with the model's view of the current cycle.
    task automatic check_cycle();
        logic rdy;
        rdy = (sched.size() == 0);
        chk("rf_we", {31'd0, rf_we}, {31'd0, cur.we});
        chk("exc_pulse", {31'd0, exc_pulse}, {31'd0, cur.pulse});
        chk("wb_ready", {31'd0, wb_ready}, {31'd0, rdy});
        chk("stall", {31'd0, stall}, {31'd0, !rdy});
        chk("of_flag", {31'd0, of_flag}, {31'd0, m_of});
        chk("exc_func", {29'd0, exc_func}, {29'd0, m_exc_func});
        if (cur.we || cur.idle) begin
            chk("rf_waddr", {28'd0, rf_waddr}, {28'd0, cur.addr});
            chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, cur.data});
        end
    endtask

    // Called just after a falling edge: drive one cycle, advance the model, check.
    task automatic step(input logic v, input logic [2:0] f, input logic [31:0] d,
                        input logic o, input logic [3:0] r, input logic c);
        logic acc, exc, ovf;
        cyc_t lo, hi;
        wb_valid  = v;
        ALU_FUNC  = f;
        alu_out   = d;
        OF_detect = o;
        dest_reg  = r;
        of_clear  = c;
        acc = v && (sched.size() == 0);
        ovf = (f == 3'd0 || f == 3'd1) && o;
        exc = (f == 3'd6 || f == 3'd7) || ovf;
        @(posedge clk);
        if (acc && ovf) m_of = 1'b1;
        else if (c) m_of = 1'b0;
        if (acc) begin
            if (exc) m_exc_func = f;
            lo = '{we: !exc && (r != 4'd0), addr: r, data: d[15:0], pulse: exc, idle: 1'b0};
            sched.push_back(lo);
            if (f == 3'd4 || f == 3'd5) begin
                hi = '{we: 1'b1, addr: 4'd15, data: d[31:16], pulse: 1'b0, idle: 1'b0};
                sched.push_back(hi);
            end
        end
        cur = (sched.size() != 0) ? sched.pop_front() : IdleCyc;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle_step();
        step(1'b0, 3'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        wb_valid = 1'b0; ALU_FUNC = '0; alu_out = '0; OF_detect = 1'b0;
        dest_reg = '0; of_clear = 1'b0;
        cur = IdleCyc; m_of = 1'b0; m_exc_func = 3'd0;
        @(negedge clk);
        @(negedge clk);
        check_cycle();
        chk("reset_ready", {31'd0, wb_ready}, 32'd1);
        rst_n = 1'b1;

        // Single add: written one cycle after accept, no stall.
        step(1'b1, 3'd0, 32'h0000_1234, 1'b0, 4'd3, 1'b0);
        chk("add_wdata", {16'd0, rf_wdata}, 32'h1234);
        chk("add_waddr", {28'd0, rf_waddr}, 32'd3);
        chk("add_ready", {31'd0, wb_ready}, 32'd1);

        // Mul: low half then high half into R15 with a one-cycle stall.
        step(1'b1, 3'd4, 32'h0003_FFFE, 1'b0, 4'd5, 1'b0);
        chk("mul_lo_wdata", {16'd0, rf_wdata}, 32'hFFFE);
        chk("mul_lo_stall", {31'd0, stall}, 32'd1);
        idle_step();
        chk("mul_hi_wdata", {16'd0, rf_wdata}, 32'h0003);
        chk("mul_hi_waddr", {28'd0, rf_waddr}, 32'd15);

        // Back-to-back or results.
        step(1'b1, 3'd3, 32'h0000_0011, 1'b0, 4'd1, 1'b0);
        step(1'b1, 3'd3, 32'h0000_0022, 1'b0, 4'd2, 1'b0);
        step(1'b1, 3'd3, 32'h0000_0033, 1'b0, 4'd3, 1'b0);
        chk("or3_wdata", {16'd0, rf_wdata}, 32'h33);
        idle_step();

        // Sub overflow, then clear coincident with a second overflow, then a plain clear.
        step(1'b1, 3'd1, 32'h0000_8000, 1'b1, 4'd4, 1'b0);
        chk("ovf_we", {31'd0, rf_we}, 32'd0);
        chk("ovf_pulse", {31'd0, exc_pulse}, 32'd1);
        chk("ovf_func", {29'd0, exc_func}, 32'd1);
        idle_step();
        step(1'b1, 3'd0, 32'h0000_0001, 1'b1, 4'd6, 1'b1);
        chk("ovf_set_wins", {31'd0, of_flag}, 32'd1);
        step(1'b0, 3'd0, 32'd0, 1'b0, 4'd0, 1'b1);
        chk("of_cleared", {31'd0, of_flag}, 32'd0);

        // Div to R0: only the high half is written; then an illegal function.
        step(1'b1, 3'd5, 32'h0001_0007, 1'b0, 4'd0, 1'b0);
        chk("div_r0_we", {31'd0, rf_we}, 32'd0);
        idle_step();
        chk("div_hi_wdata", {16'd0, rf_wdata}, 32'h0001);
        step(1'b1, 3'd7, 32'h1234_5678, 1'b0, 4'd9, 1'b0);
        chk("ill_pulse", {31'd0, exc_pulse}, 32'd1);
        chk("ill_func", {29'd0, exc_func}, 32'd7);
        idle_step();

        // Reset in the HI cycle of a mul abandons the pending write.
        step(1'b1, 3'd4, 32'hABCD_0102, 1'b0, 4'd7, 1'b0);
        idle_step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_ready", {31'd0, wb_ready}, 32'd1);
        sched.delete();
        cur = IdleCyc; m_of = 1'b0; m_exc_func = 3'd0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_cycle();
        idle_step();
        idle_step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15)
                                            : 4'($urandom);
            step(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) == 0), r, ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
